// File: rtl/axi4_wr_addr_fifo.sv
// AXI4 write-address channel slave with a DEPTH-entry first-word-fall-through command FIFO.
// Each AW beat is classified for protocol errors when it is captured; erroneous commands are
// still queued (with cmd_err_o set) so the downstream logic can answer them with SLVERR.
//
// Ports:
//   axi_clk_i, axi_rstn_i        clock (rising edge) and async active-low reset
//   axi_aw*_i, axi_awvalid_i     AW channel inputs
//   axi_awready_o                AW ready, registered (never a function of axi_awvalid_i)
//   cmd_valid_o / cmd_ready_i    head-of-queue handshake toward write-data/response logic
//   cmd_*_o, cmd_err_o           head entry fields, meaningful only while cmd_valid_o is high
//   level_o                      current occupancy, 0..DEPTH
module axi4_wr_addr_fifo #(
  parameter int unsigned AXI_AW  = 32,
  parameter int unsigned AXI_IW  = 4,
  parameter int unsigned AXI_DW  = 32,
  parameter int unsigned AWLEN_W = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     axi_clk_i,
  input  logic                     axi_rstn_i,
  input  logic [AXI_IW-1:0]        axi_awid_i,
  input  logic [AXI_AW-1:0]        axi_awaddr_i,
  input  logic [AWLEN_W-1:0]       axi_awlen_i,
  input  logic [2:0]               axi_awsize_i,
  input  logic [1:0]               axi_awburst_i,
  input  logic                     axi_awlock_i,
  input  logic [3:0]               axi_awcache_i,
  input  logic [2:0]               axi_awprot_i,
  input  logic                     axi_awvalid_i,
  output logic                     axi_awready_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [AXI_IW-1:0]        cmd_id_o,
  output logic [AXI_AW-1:0]        cmd_addr_o,
  output logic [AWLEN_W-1:0]       cmd_len_o,
  output logic [2:0]               cmd_size_o,
  output logic [1:0]               cmd_burst_o,
  output logic                     cmd_lock_o,
  output logic [3:0]               cmd_cache_o,
  output logic [2:0]               cmd_prot_o,
  output logic                     cmd_err_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned LvlW    = PtrW + 1;
  localparam logic [2:0]  MaxSize = 3'($clog2(AXI_DW / 8));

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] BurstWrap = 2'b10;
  localparam logic [1:0] BurstRsvd = 2'b11;

  typedef struct packed {
    logic [AXI_IW-1:0]  id;
    logic [AXI_AW-1:0]  addr;
    logic [AWLEN_W-1:0] len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic               err;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            awready_q, valid_q;
  logic            push, pop;
  logic            wrap_len_ok, err;
  logic [19:0]     span;

  assign push = axi_awvalid_i && awready_q;
  assign pop  = valid_q && cmd_ready_i;

  // Error classification. span is the 4 KB-page offset of the last beat's aligned start;
  // any bit above 11 means the INCR burst leaves its page.
  always_comb begin
    span        = {8'd0, axi_awaddr_i[11:0]} >> axi_awsize_i;
    span        = span + 20'(axi_awlen_i);
    span        = span << axi_awsize_i;
    wrap_len_ok = (axi_awlen_i == AWLEN_W'(1)) || (axi_awlen_i == AWLEN_W'(3)) ||
                  (axi_awlen_i == AWLEN_W'(7)) || (axi_awlen_i == AWLEN_W'(15));
    err         = 1'b0;
    if (axi_awburst_i == BurstRsvd)                      err = 1'b1;
    if (axi_awsize_i > MaxSize)                          err = 1'b1;
    if ((axi_awburst_i == BurstWrap) && !wrap_len_ok)    err = 1'b1;
    if ((axi_awburst_i == BurstIncr) && (span[19:12] != 8'd0)) err = 1'b1;
  end

  always_comb begin
    wr_entry.id    = axi_awid_i;
    wr_entry.addr  = axi_awaddr_i;
    wr_entry.len   = axi_awlen_i;
    wr_entry.size  = axi_awsize_i;
    wr_entry.burst = axi_awburst_i;
    wr_entry.lock  = axi_awlock_i;
    wr_entry.cache = axi_awcache_i;
    wr_entry.prot  = axi_awprot_i;
    wr_entry.err   = err;
  end

  always_comb begin
    level_d = level_q + LvlW'(push) - LvlW'(pop);
  end

  // Storage is deliberately not reset; validity is tracked by level_q/valid_q alone.
  always_ff @(posedge axi_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      awready_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q   <= level_d;
      // Ready is computed from the next level, so a pop while full frees a slot only from
      // the following cycle onward.
      awready_q <= (level_d != LvlW'(DEPTH));
      valid_q   <= (level_d != '0);
    end
  end

  assign axi_awready_o = awready_q;
  assign cmd_valid_o   = valid_q;
  assign level_o       = level_q;
  assign cmd_id_o      = mem_q[rd_ptr_q].id;
  assign cmd_addr_o    = mem_q[rd_ptr_q].addr;
  assign cmd_len_o     = mem_q[rd_ptr_q].len;
  assign cmd_size_o    = mem_q[rd_ptr_q].size;
  assign cmd_burst_o   = mem_q[rd_ptr_q].burst;
  assign cmd_lock_o    = mem_q[rd_ptr_q].lock;
  assign cmd_cache_o   = mem_q[rd_ptr_q].cache;
  assign cmd_prot_o    = mem_q[rd_ptr_q].prot;
  assign cmd_err_o     = mem_q[rd_ptr_q].err;

endmodule
